rf_sync_tx: RTL and testbench

Transmit-side pulse-train generator for the RF sync link. It is the other end of fsm_sync. It drives rfout with one fixed-width pulse per slot period at a fixed in-slot position, and emits the sh_en sample/hold strobe at every slot boundary. Frames are on-off keyed: PRE_SLOTS preamble slots (pulse always present), then DATA_BITS data slots (pulse present = 1), MSB first. It sits between the control logic, which supplies words over a valid/ready handshake, and the RF output driver.

---
 rtl/rf_sync_tx.sv | 117 +++++++++++
 tb/tb_rf_sync_tx.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/rf_sync_tx.sv
// OOK slot-pulse transmitter: preamble pulses then MSB-first data pulses, sh_en at each slot start.
// Outputs registered (1 cycle); tx_ready only while idle and enabled, so a word waits in the caller.
module rf_sync_tx #(
  parameter int PERIOD_CYC = 10000,
  parameter int POS_CYC    = 3000,
  parameter int HIGH_CYC   = 1,
  parameter int PRE_SLOTS  = 4,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 rfout,
  output logic                 sh_en,
  output logic                 frame_done,
  output logic [1:0]           state
);

  localparam int CW   = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
  localparam int MAXS = (PRE_SLOTS > DATA_BITS) ? PRE_SLOTS : DATA_BITS;
  localparam int SW   = (MAXS > 1) ? $clog2(MAXS) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_PRE   = 2'd2,
    S_DATA  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [SW-1:0]        slot_q, slot_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 rfout_q, sh_en_q, done_q;
  logic                 rfout_d, sh_en_d, done_d;
  logic                 wrap, hs, bit_d, win_d;

  assign tx_ready = (state_q == S_IDLE) && en;

  always_comb begin
    wrap    = en && (cnt_q == CW'(PERIOD_CYC - 1));
    hs      = tx_valid && tx_ready;
    cnt_d   = en ? (wrap ? '0 : cnt_q + 1'b1) : '0;
    state_d = state_q;
    slot_d  = slot_q;
    shift_d = shift_q;
    if (!en) begin
      // Disabling aborts any frame and drops the latched word.
      state_d = S_IDLE;
      slot_d  = '0;
      shift_d = '0;
    end else begin
      case (state_q)
        S_IDLE: if (hs) begin
          shift_d = tx_data;
          slot_d  = '0;
          state_d = wrap ? S_PRE : S_ARMED;
        end
        S_ARMED: if (wrap) state_d = S_PRE;
        S_PRE: if (wrap) begin
          if (slot_q == SW'(PRE_SLOTS - 1)) begin
            state_d = S_DATA;
            slot_d  = '0;
          end else begin
            slot_d = slot_q + 1'b1;
          end
        end
        S_DATA: if (wrap) begin
          shift_d = shift_q << 1;
          if (slot_q == SW'(DATA_BITS - 1)) begin
            state_d = S_IDLE;
            slot_d  = '0;
          end else begin
            slot_d = slot_q + 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    // Outputs are registered, so they are decoded from next-cycle state.
    bit_d   = (state_d == S_PRE) || ((state_d == S_DATA) && shift_d[DATA_BITS-1]);
    win_d   = (cnt_d >= CW'(POS_CYC)) && (cnt_d <= CW'(POS_CYC + HIGH_CYC - 1));
    rfout_d = en && bit_d && win_d;
    sh_en_d = en && (cnt_d == '0);
    done_d  = en && (state_d == S_DATA) && (slot_d == SW'(DATA_BITS - 1)) &&
              (cnt_d == CW'(PERIOD_CYC - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      slot_q  <= '0;
      shift_q <= '0;
      rfout_q <= 1'b0;
      sh_en_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      slot_q  <= slot_d;
      shift_q <= shift_d;
      rfout_q <= rfout_d;
      sh_en_q <= sh_en_d;
      done_q  <= done_d;
    end
  end

  assign rfout      = rfout_q;
  assign sh_en      = sh_en_q;
  assign frame_done = done_q;
  assign state      = state_q;

endmodule

// File: tb/tb_rf_sync_tx.sv
// Bench for rf_sync_tx: directed scenarios plus random traffic against a slot-arithmetic frame model.
module tb_rf_sync_tx;
  localparam int P    = 20;
  localparam int POS  = 6;
  localparam int HI   = 2;
  localparam int PRE  = 2;
  localparam int DB   = 4;
  localparam int FLEN = (PRE + DB) * P;

  logic          clk = 1'b0;
  logic          rst, en, tx_valid;
  logic [DB-1:0] tx_data;
  logic          tx_ready, rfout, sh_en, frame_done;
  logic [1:0]    state;

  int errors = 0;
  int checks = 0;

  // Model: enabled edges since last disable/reset, and the edge count at which the preamble starts.
  int            ecount = 0;
  int            fstart = -1;
  logic [DB-1:0] word   = '0;
  bit            last_hs = 1'b0;

  rf_sync_tx #(
    .PERIOD_CYC(P), .POS_CYC(POS), .HIGH_CYC(HI), .PRE_SLOTS(PRE), .DATA_BITS(DB)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .rfout(rfout), .sh_en(sh_en), .frame_done(frame_done),
    .state(state)
  );

  always #5 clk = ~clk;

  function automatic bit m_idle();
    return (fstart < 0) || (ecount >= fstart + FLEN);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h (ecount=%0d)", tag, obs, exp, ecount);
    end
  endtask

  task automatic check_outputs();
    int   cnt, rel, slot;
    logic [1:0] es;
    bit   er, ed, bitv;
    cnt = ecount % P;
    es  = 2'd0;
    er  = 1'b0;
    ed  = 1'b0;
    if (!m_idle()) begin
      rel = ecount - fstart;
      if (rel < 0) begin
        es = 2'd1;
      end else begin
        slot = rel / P;
        es   = (slot < PRE) ? 2'd2 : 2'd3;
        bitv = (slot < PRE) ? 1'b1 : word[DB-1-(slot-PRE)];
        er   = bitv && (cnt >= POS) && (cnt < POS + HI);
        ed   = (rel == FLEN - 1);
      end
    end
    chk("state", 32'(state), 32'(es));
    chk("rfout", 32'(rfout), 32'(er));
    chk("sh_en", 32'(sh_en), 32'((ecount > 0) && (cnt == 0)));
    chk("frame_done", 32'(frame_done), 32'(ed));
    chk("tx_ready", 32'(tx_ready), 32'(m_idle() && en));
  endtask

  task automatic tick();
    bit hs;
    hs      = m_idle() && en && tx_valid;
    last_hs = hs;
    @(posedge clk);
    if (!en) begin
      ecount = 0;
      fstart = -1;
    end else begin
      ecount++;
      if (hs) begin
        fstart = ((ecount + P - 1) / P) * P;
        word   = tx_data;
      end
    end
    #1;
    check_outputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic timeout(input string tag);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired (ecount=%0d)", tag, ecount);
  endtask

  task automatic wait_idle_cnt(input int c);
    int i;
    for (i = 0; i < 400; i++) begin
      if (m_idle() && (ecount % P == c)) break;
      tick();
    end
    if (i == 400) timeout("wait_idle_cnt");
  endtask

  task automatic wait_rel(input int r);
    int i;
    for (i = 0; i < 400; i++) begin
      if (fstart >= 0 && ecount == fstart + r) break;
      tick();
    end
    if (i == 400) timeout("wait_rel");
  endtask

  task automatic send(input logic [DB-1:0] d);
    tx_valid = 1'b1;
    tx_data  = d;
    tick();
    tx_valid = 1'b0;
    tx_data  = DB'($urandom);
  endtask

  initial begin
    int i;
    rst = 1'b1; en = 1'b0; tx_valid = 1'b0; tx_data = '0;
    #2;
    chk("rst_rfout", 32'(rfout), 32'd0);
    chk("rst_sh_en", 32'(sh_en), 32'd0);
    chk("rst_done", 32'(frame_done), 32'd0);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_ready", 32'(tx_ready), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b1;

    // Idle timebase
    run(100);

    // Frame 1010 with handshake at cnt 5
    wait_idle_cnt(5);
    send(4'b1010);
    run(FLEN + 40);

    // Handshake in the wrap cycle starts the preamble immediately
    wait_idle_cnt(19);
    send(4'b1111);
    run(FLEN + 20);

    // Back-to-back words with tx_valid held high
    wait_idle_cnt(3);
    tx_valid = 1'b1;
    tx_data  = 4'b0001;
    tick();
    tx_data = 4'b1000;
    for (i = 0; i < 2 * FLEN; i++) begin
      tick();
      if (last_hs) break;
    end
    if (i == 2 * FLEN) timeout("b2b_second_hs");
    tx_valid = 1'b0;
    run(FLEN + P);

    // Disable during the first data slot while the pulse is high
    wait_idle_cnt(0);
    send({1'b1, 3'($urandom)});
    wait_rel(PRE * P + 7);
    chk("pre_drop_rfout", 32'(rfout), 32'd1);
    en = 1'b0;
    tick();
    run(5);
    en = 1'b1;
    run(50);

    // Asynchronous reset mid-pulse
    wait_idle_cnt(0);
    send(4'b0110);
    wait_rel(6);
    #3 rst = 1'b1;
    #1;
    chk("arst_rfout", 32'(rfout), 32'd0);
    chk("arst_sh_en", 32'(sh_en), 32'd0);
    chk("arst_state", 32'(state), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("arst_hold_state", 32'(state), 32'd0);
    chk("arst_hold_sh_en", 32'(sh_en), 32'd0);
    ecount = 0;
    fstart = -1;
    #2 rst = 1'b0;
    run(100);

    // Random traffic with occasional disables
    for (int k = 0; k < 3000; k++) begin
      en       = ($urandom % 250) != 0;
      tx_valid = ($urandom % 6) == 0;
      tx_data  = DB'($urandom);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
